// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared external 6-bit adder.
// It grants one requester, drives the adder, registers sum and carry, and returns them on a valid/ready channel.
module adder_arbiter #(
   parameter int ID_W  = 2,
   parameter int WIDTH = 6,
   localparam int N_REQ = 2**ID_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_a,
   input  logic [N_REQ*WIDTH-1:0]   req_b,
   output logic [N_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   input  logic [WIDTH-1:0]         add_sum,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_ovf,
   output logic                     busy
);

   // state | meaning
   // IDLE  | search for a winner from rr_ptr; grant and capture operands
   // EXEC  | operands on the shared adder; capture sum and carry
   // RESP  | result presented; wait for rsp_ready

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  id;
   logic [WIDTH-1:0] op_a, op_b;
   logic             grant_hit;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  cand;

   // Search wraps naturally because cand is ID_W bits wide.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = rr_ptr;
      cand      = rr_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         cand = rr_ptr + k[ID_W-1:0];
         if (!grant_hit && req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_hit) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // req_ready is held low while rst is high, even if requests are pending.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_hit && !rst) req_ready[grant_idx] = 1'b1;
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         id      <= '0;
         op_a    <= '0;
         op_b    <= '0;
         rsp_id  <= '0;
         rsp_sum <= '0;
         rsp_ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: if (grant_hit) begin
               op_a <= req_a[grant_idx*WIDTH +: WIDTH];
               op_b <= req_b[grant_idx*WIDTH +: WIDTH];
               id   <= grant_idx;
            end
            EXEC: begin
               rsp_sum <= add_sum;
               // A truncated sum smaller than an operand means the addition carried out.
               rsp_ovf <= (add_sum < op_a);
               rsp_id  <= id;
            end
            RESP: if (rsp_ready) rr_ptr <= id + 1'b1;
            default: ;
         endcase
      end
   end

   assign add_a = op_a;
   assign add_b = op_b;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter.
// The bench provides the shared adder and predicts grants and results from a round-robin pointer model.
module tb_adder_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [23:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic [5:0]  add_a, add_b, add_sum;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic [5:0]  rsp_sum;
   logic        rsp_ovf;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;
   int m_ptr    = 0;
   int m_last_a = 0;
   int m_last_b = 0;

   always #5 clk = ~clk;

   assign add_sum = add_a + add_b;

   adder_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int winner(input logic [3:0] v, input int ptr);
      for (int k = 0; k < 4; k++)
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   // Called just after a falling edge while the DUT is idle; returns just after the falling edge that sees IDLE again.
   task automatic do_txn(input logic [3:0] v, input logic [23:0] a, input logic [23:0] b, input int stall);
      int g, ea, eb, s;
      req_valid = v; req_a = a; req_b = b; rsp_ready = 1'b0;
      #1;
      g = winner(v, m_ptr);
      if (g < 0) begin
         chk("idle_ready", req_ready, 0);
         chk("idle_busy", busy, 0);
         chk("idle_add_a", add_a, m_last_a);
         @(negedge clk);
         return;
      end
      ea = a[g*6 +: 6];
      eb = b[g*6 +: 6];
      s  = ea + eb;
      chk("grant", req_ready, 32'd1 << g);
      chk("grant_busy", busy, 0);
      @(negedge clk); #1;
      chk("exec_busy", busy, 1);
      chk("exec_ready", req_ready, 0);
      chk("exec_valid", rsp_valid, 0);
      chk("exec_add_a", add_a, ea);
      chk("exec_add_b", add_b, eb);
      m_last_a = ea; m_last_b = eb;
      @(negedge clk); #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_sum", rsp_sum, s % 64);
      chk("rsp_ovf", rsp_ovf, s > 63);
      chk("rsp_ready_low", req_ready, 0);
      repeat (stall) begin
         @(negedge clk); #1;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_id", rsp_id, g);
         chk("hold_sum", rsp_sum, s % 64);
         chk("hold_ready", req_ready, 0);
         chk("hold_add_a", add_a, ea);
      end
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      m_ptr = (g + 1) % 4;
      chk("done_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
   endtask

   initial begin
      int g;
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      #2;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_add", {add_a, add_b}, 0);
      chk("rst_rsp", {rsp_id, rsp_sum, rsp_ovf}, 0);
      @(negedge clk); rst = 1'b0;

      // Round robin from pointer 0: requester r gets operands (a[r], b[r]).
      for (int t = 0; t < 5; t++)
         do_txn(4'b1111, {6'd17, 6'd63, 6'd25, 6'd9}, {6'd20, 6'd1, 6'd34, 6'd2}, 0);

      // Single request from requester 0: 5 + 3.
      do_txn(4'b0001, {18'd0, 6'b000101}, {18'd0, 6'b000011}, 0);
      // Overflow from requester 2: 40 + 30 wraps to 6.
      do_txn(4'b0100, {6'd0, 6'd40, 12'd0}, {6'd0, 6'd30, 12'd0}, 0);
      // Backpressure with requester 1 waiting; it must win the next arbitration.
      do_txn(4'b0011, {12'd0, 6'd11, 6'd33}, {12'd0, 6'd7, 6'd44}, 5);
      do_txn(4'b0010, {12'd0, 6'd11, 6'd33}, {12'd0, 6'd7, 6'd44}, 0);

      req_valid = '0;
      repeat (10) begin
         @(negedge clk); #1;
         chk("idle_hold_ready", req_ready, 0);
         chk("idle_hold_busy", busy, 0);
         chk("idle_hold_valid", rsp_valid, 0);
         chk("idle_hold_ops", {add_a, add_b}, {m_last_a[5:0], m_last_b[5:0]});
      end

      // Reset while EXEC: everything clears immediately and the dropped request never responds.
      req_valid = 4'b0100; req_a = {6'd0, 6'd12, 12'd0}; req_b = {6'd0, 6'd13, 12'd0};
      @(negedge clk); #1;
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1; #1;
      chk("async_busy", busy, 0);
      chk("async_valid", rsp_valid, 0);
      chk("async_ops", {add_a, add_b}, 0);
      chk("async_ready", req_ready, 0);
      req_valid = 4'b1000;
      repeat (2) begin
         @(negedge clk); #1;
         chk("in_rst_valid", rsp_valid, 0);
      end
      rst = 1'b0; m_ptr = 0; m_last_a = 0; m_last_b = 0;
      #1;
      chk("post_rst_grant", req_ready, 4'b1000);
      do_txn(4'b1000, {6'd21, 18'd0}, {6'd22, 18'd0}, 0);

      for (int i = 0; i < 40; i++)
         do_txn($urandom_range(0, 15), {$urandom} & 24'hFFFFFF, {$urandom} & 24'hFFFFFF,
                $urandom_range(0, 3));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
